// File: rtl/dadda_mul_pkg.sv
// ============================================================================
// Package : dadda_mul_pkg
// Shared types, constants and bit-level helpers for the Dadda multiplier slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package dadda_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  // Number of slice-pair partial products for one full-width multiply.
  function automatic int steps(input int in_w);
    return (in_w / SLICE_W) * (in_w / SLICE_W);
  endfunction

  // Half adder, result packed as {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder, result packed as {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

endpackage : dadda_mul_pkg

`default_nettype wire

// File: rtl/daddamul88.sv
// ============================================================================
// Module : daddamul88
// Combinational 4x4 unsigned Dadda multiplier (two reduction stages + final CPA)
// Revision: 1.0
// ============================================================================
`default_nettype none

module daddamul88
  import dadda_mul_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Y
);

  // pp[i][j] = A[j] & B[i], weight i+j
  logic [3:0] pp [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp_row
      assign pp[gi] = A & {4{B[gi]}};
    end
  endgenerate

  logic s1, c1, s2, c2;
  logic s3, c3, s4, c4, s5, c5, s6, c6;
  logic [7:0] row_x;
  logic [7:0] row_y;

  // Stage 1: column heights 4 -> 3
  assign {c1, s1} = ha(pp[0][3], pp[1][2]);
  assign {c2, s2} = ha(pp[1][3], pp[2][2]);

  // Stage 2: column heights 3 -> 2
  assign {c3, s3} = ha(pp[0][2], pp[1][1]);
  assign {c4, s4} = fa(s1, pp[2][1], pp[3][0]);
  assign {c5, s5} = fa(s2, pp[3][1], c1);
  assign {c6, s6} = fa(pp[2][3], pp[3][2], c2);

  assign row_x = {1'b0, pp[3][3], s6, s5, s4, s3, pp[0][1], pp[0][0]};
  assign row_y = {1'b0, c6, c5, c4, c3, pp[2][0], pp[1][0], 1'b0};

  assign Y = row_x + row_y;

endmodule : daddamul88

`default_nettype wire

// File: rtl/dadda_mul_seq.sv
// ============================================================================
// Module : dadda_mul_seq
// Multi-cycle IN_W x IN_W unsigned multiplier sharing one 4x4 Dadda core
// Revision: 1.0
// ============================================================================
`default_nettype none

module dadda_mul_seq
  import dadda_mul_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*IN_W-1:0] product_o,
  output logic              busy_o
);

  localparam int SLICES = IN_W / SLICE_W;
  localparam int STEPS  = steps(IN_W);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int P_W    = 2 * IN_W;

  localparam logic [STEP_W-1:0] C_SLICES    = STEP_W'(SLICES);
  localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(STEPS - 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q,  step_d;
  logic [IN_W-1:0]     a_q,     a_d;
  logic [IN_W-1:0]     b_q,     b_d;
  logic [P_W-1:0]      acc_q,   acc_d;

  logic [STEP_W-1:0]   ai;
  logic [STEP_W-1:0]   bj;
  logic [STEP_W:0]     slice_sum;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [7:0]          pp;
  logic [P_W-1:0]      term;
  logic                zero_op;

  // Slice selection: a-slice cycles fastest, b-slice advances once per row
  assign ai        = step_q % C_SLICES;
  assign bj        = step_q / C_SLICES;
  assign slice_sum = {1'b0, ai} + {1'b0, bj};

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < SLICES; k++) begin
      if (ai == STEP_W'(k)) slice_a = a_q[k*SLICE_W +: SLICE_W];
      if (bj == STEP_W'(k)) slice_b = b_q[k*SLICE_W +: SLICE_W];
    end
  end

  daddamul88 u_core (
    .A (slice_a),
    .B (slice_b),
    .Y (pp)
  );

  assign term    = P_W'(pp) << {slice_sum, 2'b00};
  assign zero_op = (a_i == '0) || (b_i == '0);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          step_d  = '0;
          state_d = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + term;
        if (step_q == C_LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake outputs decode the state register only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy_o    = (state_q != IDLE);
  assign product_o = acc_q;

endmodule : dadda_mul_seq

`default_nettype wire

// File: tb/tb_dadda_mul_seq.sv
// ============================================================================
// Module : tb_dadda_mul_seq
// Self-checking bench for dadda_mul_seq at IN_W=8 and IN_W=16
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dadda_mul_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] product16;
  logic        busy16;

  int errors;
  int checks;

  dadda_mul_seq #(.IN_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product_o (product),
    .busy_o    (busy)
  );

  dadda_mul_seq #(.IN_W(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a_i       (a16),
    .b_i       (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .product_o (product16),
    .busy_o    (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge with the 8-bit DUT idle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input int lat, input string nm);
    int n;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    a_i = a; b_i = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_product"}, 32'(product), 32'(exp));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_hold_idle"}, 32'(product), 32'(exp));
    chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs [10];
    int   n;
    bit   got;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;

    errors = 0;
    checks = 0;
    vecs[0] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01, lat: 5};
    vecs[1] = '{a: 8'h00, b: 8'h5A, exp: 16'h0000, lat: 1};
    vecs[2] = '{a: 8'h5A, b: 8'h00, exp: 16'h0000, lat: 1};
    vecs[3] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8, lat: 5};
    vecs[4] = '{a: 8'hAB, b: 8'hCD, exp: 16'h88EF, lat: 5};
    vecs[5] = '{a: 8'h01, b: 8'h01, exp: 16'h0001, lat: 5};
    vecs[6] = '{a: 8'h80, b: 8'h02, exp: 16'h0100, lat: 5};
    vecs[7] = '{a: 8'hFF, b: 8'h01, exp: 16'h00FF, lat: 5};
    vecs[8] = '{a: 8'h0F, b: 8'hF0, exp: 16'h0E10, lat: 5};
    vecs[9] = '{a: 8'h10, b: 8'h10, exp: 16'h0100, lat: 5};

    rst_n = 1'b0;
    in_valid = 1'b0; a_i = '0; b_i = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_product16", product16, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_in_ready16", 32'(in_ready16), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result must stay put while out_ready is low.
    a_i = 8'h12; b_i = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 32'(n), 32'd5);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_product", 32'(product), 32'h03A8);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", 32'(in_ready), 32'd1);

    // in_valid during CALC must not disturb the running operation.
    a_i = 8'h0F; b_i = 8'h10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovl_in_ready", 32'(in_ready), 32'd0);
    a_i = 8'h77; b_i = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 3;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ovl_latency", 32'(n), 32'd5);
    chk("ovl_product", 32'(product), 32'h00F0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovl_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of CALC discards the operation.
    a_i = 8'hAB; b_i = 8'hCD; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_product", 32'(product), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_no_output", 32'(out_valid), 32'd0);
    chk("mrst_product_hold", 32'(product), 32'd0);

    // Random operands with random consumer backpressure, 8-bit.
    for (int t = 0; t < 1000; t++) begin
      ra = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      a_i = ra; b_i = rb; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 200) begin
        if (out_valid) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_ready) begin
            chk("rnd8_product", 32'(product), 32'(ra) * 32'(rb));
            got = 1'b1;
          end
        end
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      if (!got) chk("rnd8_timeout", 32'(got), 32'd1);
    end

    // 16-bit instance: full-scale latency, then random operands.
    a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    n = 1;
    while (!out_valid16 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("w16_latency", 32'(n), 32'd17);
    chk("w16_product", product16, 32'hFFFE0001);
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;

    for (int t = 0; t < 300; t++) begin
      wa = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
      wb = 16'($urandom_range(0, 65535));
      a16 = wa; b16 = wb; in_valid16 = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 200) begin
        if (out_valid16) begin
          out_ready16 = 1'($urandom_range(0, 1));
          if (out_ready16) begin
            chk("rnd16_product", product16, 32'(wa) * 32'(wb));
            got = 1'b1;
          end
        end
        @(negedge clk);
        n++;
      end
      out_ready16 = 1'b0;
      if (!got) chk("rnd16_timeout", 32'(got), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dadda_mul_seq

`default_nettype wire
